// File: rtl/udma_eth_frame_pkg.sv
// ============================================================================
// Module      : udma_eth_frame_pkg
// Description : Shared types for the uDMA Ethernet frame receive buffer:
//               the per-frame descriptor, the read-side state encoding and
//               the mapping from word width to the uDMA datasize code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udma_eth_frame_pkg;

    // Descriptor length field is sized for the largest supported buffer
    // (32 KiB); narrower instances use the low LEN_WIDTH bits.
    localparam int ETH_DESC_LEN_W = 16;

    typedef struct packed {
        logic [ETH_DESC_LEN_W-1:0] len;
        logic                      err;
    } eth_rx_desc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } rx_rd_state_e;

    function automatic logic [1:0] bpw_to_datasize(input int bpw);
        case (bpw)
            1:       return 2'd0;
            2:       return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/udma_eth_frame_desc_fifo.sv
// ============================================================================
// Module      : udma_eth_frame_desc_fifo
// Description : Synchronous FIFO of frame descriptors. A push while full is
//               accepted when a pop happens in the same cycle.
// Ports       : clk_i, rstn_i (sync, active-low), i_push/i_din, i_pop,
//               o_dout (head entry), o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_eth_frame_desc_fifo
    import udma_eth_frame_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         i_push,
    input  eth_rx_desc_t i_din,
    input  logic         i_pop,
    output eth_rx_desc_t o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    eth_rx_desc_t  r_mem [DEPTH];
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr[AW-1:0]] <= i_din;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/udma_eth_frame_rx_buf.sv
// ============================================================================
// Module      : udma_eth_frame_rx_buf
// Description : Frame-aware RX buffer between a MAC AXIS byte stream and the
//               uDMA RX channel. Frames are written speculatively and either
//               committed (descriptor pushed) or rolled back. The read side
//               packs bytes into uDMA words and parks at each frame end until
//               release_i.
// Option      : ETH_FRAME_RX_DROP_EN - roll back frames flagged by s_tuser
//               instead of committing them with err=1.
// Ports       : clk_i/rstn_i (sync, active-low); s_t* AXIS byte input;
//               data_rx_* uDMA word output; frame_avail_o/frame_len_o/
//               frame_err_o head descriptor; eof_o end-of-frame pulse;
//               release_i frame release; drop_cnt_o dropped-frame count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udma_eth_frame_rx_buf
    import udma_eth_frame_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int BUFFER_DEPTH   = 2048,
    parameter int MAX_FRAMES     = 8,
    parameter int LEN_WIDTH      = $clog2(BUFFER_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [7:0]           s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic                 s_tuser,
    output logic [31:0]          data_rx_o,
    output logic [1:0]           data_rx_datasize_o,
    output logic                 data_rx_valid_o,
    input  logic                 data_rx_ready_i,
    output logic                 frame_avail_o,
    output logic [LEN_WIDTH-1:0] frame_len_o,
    output logic                 frame_err_o,
    output logic                 eof_o,
    input  logic                 release_i,
    output logic [15:0]          drop_cnt_o
);

    localparam int AW = LEN_WIDTH - 1;

    // ---------------- write side ----------------
    logic [7:0]           r_mem [BUFFER_DEPTH];
    logic [7:0]           r_ram_q;
    logic [LEN_WIDTH-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_len;
    logic                 r_ovf;
    logic [15:0]          r_drop_cnt;
    logic [LEN_WIDTH-1:0] w_used;
    logic                 w_ovf, w_err_drop, w_desc_err, w_wr_en, w_commit, w_drop, w_pop;
    logic                 w_desc_full, w_desc_empty;
    eth_rx_desc_t         w_din, w_head;
    logic                 w_unused_bits;

    // ---------------- read side ----------------
    rx_rd_state_e         r_state;
    logic [LEN_WIDTH-1:0] r_raddr, r_issue_left, r_recv_left;
    logic                 r_rd_vld, r_last_word, r_out_vld, r_eof;
    logic [31:0]          r_pack, r_out_data, w_word;
    logic [1:0]           r_bcnt;   // bytes already in the pack register
    logic [2:0]           r_wcnt;   // reads issued for the current word
    logic                 w_rd_issue;

`ifdef ETH_FRAME_RX_DROP_EN
    assign w_err_drop = s_tuser;
    assign w_desc_err = 1'b0;
`else
    assign w_err_drop = 1'b0;
    assign w_desc_err = s_tuser;
`endif

    assign w_used = r_wr_ptr - r_rd_ptr;
    assign w_pop  = (r_state == HOLD) && release_i;
    // A pop in this cycle frees a descriptor slot, so a full queue does not
    // overflow a frame that commits alongside a release.
    assign w_ovf  = r_ovf || (w_used == LEN_WIDTH'(BUFFER_DEPTH)) || (w_desc_full && !w_pop);

    assign w_wr_en  = s_tvalid && !w_ovf && !(s_tlast && w_err_drop);
    assign w_commit = s_tvalid && s_tlast && !w_ovf && !w_err_drop;
    assign w_drop   = s_tvalid && s_tlast && (w_ovf || w_err_drop);

    assign w_din.len = ETH_DESC_LEN_W'(r_len + 1'b1);
    assign w_din.err = w_desc_err;

    udma_eth_frame_desc_fifo #(
        .DEPTH (MAX_FRAMES)
    ) u_desc_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .i_push  (w_commit),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_desc_full),
        .o_empty (w_desc_empty)
    );

    assign w_unused_bits = ^{w_head.len, w_head.err};

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (s_tvalid) begin
            if (s_tlast) begin
                r_len <= '0;
                r_ovf <= 1'b0;
                if (w_drop) begin
                    r_wr_ptr <= r_cm_ptr;
                    if (r_drop_cnt != 16'hFFFF) begin
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_cm_ptr <= r_wr_ptr + 1'b1;
                end
            end else if (w_ovf) begin
                r_ovf <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_len    <= r_len + 1'b1;
            end
        end
    end

    // Byte RAM: one write port, one registered read port.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_tdata;
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[r_raddr[AW-1:0]];
        end
    end

    // Reads are only issued while the output register is empty, so no byte
    // is ever in flight while a finished word waits for the uDMA.
    assign w_rd_issue = (r_state == STREAM) && !r_out_vld && (r_issue_left != '0)
                        && (r_wcnt < 3'(BYTES_PER_WORD));

    always_comb begin
        w_word = r_pack | (32'(r_ram_q) << {r_bcnt, 3'b000});
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            r_raddr      <= '0;
            r_rd_ptr     <= '0;
            r_issue_left <= '0;
            r_recv_left  <= '0;
            r_rd_vld     <= 1'b0;
            r_pack       <= '0;
            r_bcnt       <= '0;
            r_wcnt       <= '0;
            r_out_data   <= '0;
            r_out_vld    <= 1'b0;
            r_last_word  <= 1'b0;
            r_eof        <= 1'b0;
        end else begin
            r_eof    <= 1'b0;
            r_rd_vld <= w_rd_issue;
            case (r_state)
                IDLE: begin
                    if (!w_desc_empty) begin
                        r_issue_left <= w_head.len[LEN_WIDTH-1:0];
                        r_recv_left  <= w_head.len[LEN_WIDTH-1:0];
                        r_pack       <= '0;
                        r_bcnt       <= '0;
                        r_wcnt       <= '0;
                        r_state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_rd_issue) begin
                        r_raddr      <= r_raddr + 1'b1;
                        r_issue_left <= r_issue_left - 1'b1;
                    end
                    if (r_rd_vld) begin
                        r_recv_left <= r_recv_left - 1'b1;
                        if ((r_bcnt == 2'(BYTES_PER_WORD - 1)) || (r_recv_left == LEN_WIDTH'(1))) begin
                            r_out_data  <= w_word;
                            r_out_vld   <= 1'b1;
                            r_last_word <= (r_recv_left == LEN_WIDTH'(1));
                            r_pack      <= '0;
                            r_bcnt      <= '0;
                            r_wcnt      <= '0;
                        end else begin
                            r_pack <= w_word;
                            r_bcnt <= r_bcnt + 1'b1;
                            if (w_rd_issue) begin
                                r_wcnt <= r_wcnt + 1'b1;
                            end
                        end
                    end else if (w_rd_issue) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    if (r_out_vld && data_rx_ready_i) begin
                        r_out_vld <= 1'b0;
                        if (r_last_word) begin
                            r_eof   <= 1'b1;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (release_i) begin
                        r_rd_ptr <= r_raddr;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_tready           = 1'b1;
    assign data_rx_o          = r_out_data;
    assign data_rx_valid_o    = r_out_vld;
    assign data_rx_datasize_o = bpw_to_datasize(BYTES_PER_WORD);
    assign eof_o              = r_eof;
    assign drop_cnt_o         = r_drop_cnt;
    assign frame_avail_o      = !w_desc_empty;
    assign frame_len_o        = w_desc_empty ? '0 : w_head.len[LEN_WIDTH-1:0];
`ifdef ETH_FRAME_RX_DROP_EN
    assign frame_err_o        = 1'b0;
`else
    assign frame_err_o        = !w_desc_empty && w_head.err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_udma_eth_frame_rx_buf.sv
// ============================================================================
// Module      : tb_udma_eth_frame_rx_buf
// Description : Directed self-checking bench for udma_eth_frame_rx_buf
//               (BYTES_PER_WORD=4, BUFFER_DEPTH=64, MAX_FRAMES=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udma_eth_frame_rx_buf;

    localparam int BPW = 4;
    localparam int DEP = 64;
    localparam int MF  = 8;
    localparam int LW  = 7;

    logic          clk = 1'b0;
    logic          rstn;
    logic [7:0]    s_tdata;
    logic          s_tvalid, s_tready, s_tlast, s_tuser;
    logic [31:0]   data_rx_o;
    logic [1:0]    data_rx_datasize_o;
    logic          data_rx_valid_o, data_rx_ready_i;
    logic          frame_avail_o, frame_err_o, eof_o, release_i;
    logic [LW-1:0] frame_len_o;
    logic [15:0]   drop_cnt_o;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_drop;
    logic [31:0] w_first, w_last;

    udma_eth_frame_rx_buf #(
        .BYTES_PER_WORD (BPW),
        .BUFFER_DEPTH   (DEP),
        .MAX_FRAMES     (MF)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .s_tdata            (s_tdata),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .s_tlast            (s_tlast),
        .s_tuser            (s_tuser),
        .data_rx_o          (data_rx_o),
        .data_rx_datasize_o (data_rx_datasize_o),
        .data_rx_valid_o    (data_rx_valid_o),
        .data_rx_ready_i    (data_rx_ready_i),
        .frame_avail_o      (frame_avail_o),
        .frame_len_o        (frame_len_o),
        .frame_err_o        (frame_err_o),
        .eof_o              (eof_o),
        .release_i          (release_i),
        .drop_cnt_o         (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int len, input int seed, input int w);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < BPW; j++) begin
            if (w * BPW + j < len) r[8*j +: 8] = 8'(seed + w * BPW + j);
        end
        return r;
    endfunction

    task automatic send_frame(input int len, input int seed, input bit tuser);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            s_tdata  = 8'(seed + i);
            s_tvalid = 1'b1;
            s_tlast  = (i == len - 1);
            s_tuser  = tuser && (i == len - 1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    // Drain one frame's words; leaves the reader parked at the frame end.
    task automatic read_words(input string tag, input int len, input int seed, input bit err);
        int nwords, got, eofs, nvalid, t;
        nwords = (len + BPW - 1) / BPW;
        got = 0; eofs = 0; nvalid = 0; t = 0;
        while (!frame_avail_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, ".avail"}, 32'(frame_avail_o), 32'd1);
        chk({tag, ".len"}, 32'(frame_len_o), 32'(len));
        chk({tag, ".err"}, 32'(frame_err_o), 32'(err));
        data_rx_ready_i = 1'b1;
        t = 0;
        while (got < nwords && t < 1000) begin
            if (eof_o) eofs++;
            if (data_rx_valid_o) begin
                chk($sformatf("%s.w%0d", tag, got), data_rx_o, exp_word(len, seed, got));
                if (got == 0) w_first = data_rx_o;
                w_last = data_rx_o;
                got++;
            end
            @(negedge clk);
            t++;
        end
        chk({tag, ".nwords"}, 32'(got), 32'(nwords));
        for (int i = 0; i < 6; i++) begin
            if (eof_o) eofs++;
            if (data_rx_valid_o) nvalid++;
            @(negedge clk);
        end
        data_rx_ready_i = 1'b0;
        chk({tag, ".eof_once"}, 32'(eofs), 32'd1);
        chk({tag, ".no_valid_in_hold"}, 32'(nvalid), 32'd0);
        chk({tag, ".avail_in_hold"}, 32'(frame_avail_o), 32'd1);
    endtask

    task automatic do_release();
        release_i = 1'b1;
        @(negedge clk);
        release_i = 1'b0;
    endtask

    task automatic read_frame(input string tag, input int len, input int seed, input bit err);
        read_words(tag, len, seed, err);
        do_release();
    endtask

    initial begin
        rstn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        data_rx_ready_i = 1'b0; release_i = 1'b0;
        w_first = '0; w_last = '0; exp_drop = 0;
        repeat (3) @(negedge clk);
        chk("rst.tready", 32'(s_tready), 32'd1);
        chk("rst.data", data_rx_o, 32'd0);
        chk("rst.valid", 32'(data_rx_valid_o), 32'd0);
        chk("rst.eof", 32'(eof_o), 32'd0);
        chk("rst.avail", 32'(frame_avail_o), 32'd0);
        chk("rst.len", 32'(frame_len_o), 32'd0);
        chk("rst.err", 32'(frame_err_o), 32'd0);
        chk("rst.drop", 32'(drop_cnt_o), 32'd0);
        chk("datasize", 32'(data_rx_datasize_o), 32'd2);
        rstn = 1'b1;
        @(negedge clk);

        // 64-byte good frame fills the whole buffer
        send_frame(64, 8'h00, 1'b0);
        read_words("f64", 64, 8'h00, 1'b0);
        chk("f64.first", w_first, 32'h03020100);
        do_release();
        @(negedge clk);
        chk("f64.avail_after_rel", 32'(frame_avail_o), 32'd0);

        // 61-byte frame: partial zero-padded last word
        send_frame(61, 8'h40, 1'b0);
        read_frame("f61", 61, 8'h40, 1'b0);
        chk("f61.last", w_last, 32'h0000007C);

        // Errored frame
        send_frame(20, 8'h80, 1'b1);
`ifdef ETH_FRAME_RX_DROP_EN
        exp_drop = 1;
        repeat (5) @(negedge clk);
        chk("ferr.avail", 32'(frame_avail_o), 32'd0);
`else
        exp_drop = 0;
        read_frame("ferr", 20, 8'h80, 1'b1);
`endif
        chk("ferr.drop", 32'(drop_cnt_o), 32'(exp_drop));
        send_frame(24, 8'h10, 1'b0);
        read_frame("fpost", 24, 8'h10, 1'b0);

        // Two 40-byte frames without release: second overflows the buffer
        send_frame(40, 8'h20, 1'b0);
        send_frame(40, 8'h60, 1'b0);
        exp_drop++;
        chk("ovf.drop", 32'(drop_cnt_o), 32'(exp_drop));
        chk("ovf.tready", 32'(s_tready), 32'd1);
        read_frame("ovf.f0", 40, 8'h20, 1'b0);
        @(negedge clk);
        chk("ovf.avail_after", 32'(frame_avail_o), 32'd0);

        // Descriptor queue full while reader holds frame A
        send_frame(3, 8'hA0, 1'b0);
        read_words("qA", 3, 8'hA0, 1'b0);
        for (int k = 1; k <= MF; k++) send_frame(3, 8'hA0 + 8 * k, 1'b0);
        exp_drop++;
        chk("qfull.drop", 32'(drop_cnt_o), 32'(exp_drop));
        // Release and a 1-byte frame commit on the same clock edge
        release_i = 1'b1;
        s_tdata = 8'hEE; s_tvalid = 1'b1; s_tlast = 1'b1; s_tuser = 1'b0;
        @(negedge clk);
        release_i = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("same.avail", 32'(frame_avail_o), 32'd1);
        chk("same.drop", 32'(drop_cnt_o), 32'(exp_drop));
        for (int k = 1; k < MF; k++) read_frame($sformatf("q%0d", k), 3, 8'hA0 + 8 * k, 1'b0);
        read_frame("qEE", 1, 8'hEE, 1'b0);
        @(negedge clk);
        chk("q.empty", 32'(frame_avail_o), 32'd0);

        // Reset mid-frame discards buffered and queued frames
        send_frame(5, 8'h30, 1'b0);
        @(negedge clk);
        s_tdata = 8'h55; s_tvalid = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        s_tvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mrst.avail", 32'(frame_avail_o), 32'd0);
        chk("mrst.drop", 32'(drop_cnt_o), 32'd0);
        chk("mrst.valid", 32'(data_rx_valid_o), 32'd0);
        send_frame(6, 8'hC0, 1'b0);
        read_frame("mrst.f", 6, 8'hC0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
